uart_tx_frame_ser: RTL and testbench
====================================

// Module: uart_tx_frame_ser
// PURPOSE
//  Parametrised UART transmit framer/serializer: accepts a DATA_W-bit word on a valid/ready
//  handshake, emits start bit, data bits, optional parity, STOP_BITS stop bits on tx_out.
//  Each bit lasts exactly CLKS_PER_BIT clocks. Sits between the TX holding logic and the pad.
//  Generalises the fixed 8-bit serializer to configurable width, bit order and stop count.
// PARAMETERS
//  DATA_W        8     data bits per frame (1..16)
//  CLKS_PER_BIT  5208  clk cycles per bit (50 MHz / 9600 Bd); must be >= 2
//  STOP_BITS     1     stop bits per frame (1 or 2)
//  LSB_FIRST     1     1: p_data[0] sent first; 0: p_data[DATA_W-1] sent first
//  PARITY_ODD    0     parity sense when UART_TX_PARITY_EN defined (0 even, 1 odd)
// PORTS
//  clk        in   1       single clock, all logic on rising edge
//  rst        in   1       asynchronous, active-low reset
//  p_data     in   DATA_W  word to send; sampled only at accept
//  data_valid in   1       p_data valid
//  ready      out  1       high only in IDLE; accept = data_valid & ready at rising clk
//  tx_out     out  1       serial line, idle high, registered
//  busy       out  1       high from accept until frame end (= ~ready)
//  ser_done   out  1       one-cycle pulse at end of last stop bit
// BEHAVIOUR
//  - Reset (async, rst=0): state IDLE, tx_out=1, ready=1, busy=0, ser_done=0, counters 0.
//    Reset mid-frame aborts immediately; tx_out returns high with no glitch low.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: tx_out=1. On accept, latch p_data to shift reg, go START, tx_out=0 from the
//    same edge (start bit visible in the cycle after accept). No accept -> stay IDLE.
//  - Baud counter 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT); cleared at every state/bit
//    change; bit boundary when count==CLKS_PER_BIT-1, then wraps to 0.
//  - START: 1 bit time low, then DATA.
//  - DATA: bit index 0..DATA_W-1 ($clog2 width, min 1); shift per LSB_FIRST; after bit
//    DATA_W-1 go PARITY (if enabled) else STOP.
//  - STOP: tx_out=1 for STOP_BITS bit times. On final boundary: ser_done=1 for exactly one
//    cycle, state IDLE, ready=1 in the same cycle.
//  - Back-to-back: data_valid held high in the ready cycle -> next start bit follows last
//    stop bit with zero idle gap. Frame = (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT clocks, P=0/1.
//  - data_valid while busy ignored (no queueing); p_data changes mid-frame have no effect.
//  - tx_out is a direct flop output; no combinational path from inputs to tx_out.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state after DATA, one bit time, value =
//    ^latched_data ^ PARITY_ODD; parity computed from the latched word at accept.
//  UART_TX_PARITY_EN undefined: no PARITY state, no parity logic; P=0 in frame length.
// TESTING  (CLKS_PER_BIT=4 unless noted)
//  1 Reset: rst=0 mid-DATA -> tx_out=1, ready=1, busy=0, ser_done=0 at once; frame dropped.
//  2 Single 8N1: p_data=8'hA5, valid 1 cycle -> tx_out 0,1,0,1,0,0,1,0,1,1 each 4 clk
//    (LSB first); ser_done pulses once at clk 40 after accept; ready back high same cycle.
//  3 LSB_FIRST=0, DATA_W=5, STOP_BITS=2: 5'h13 -> 0,1,0,0,1,1,1,1; frame 32 clk.
//  4 Back-to-back: valid held high, 8'h00 then 8'hFF -> no idle gap between frames; exactly
//    two ser_done pulses 40 clk apart; data_valid during busy never accepted.
//  5 UART_TX_PARITY_EN, PARITY_ODD=0: 8'h07 -> parity bit 1; PARITY_ODD=1 -> 0; 44 clk.
//  6 p_data toggled every cycle during frame of 8'h3C -> serial output still 8'h3C.

Source files
------------

// File: rtl/uart_tx_frame_ser.sv
// UART transmit framer/serializer: start bit, DATA_W data bits, optional parity, STOP_BITS stop bits.
// Optional parity bit is enabled by defining the macro UART_TX_PARITY_EN.
`timescale 1ns/1ps
module uart_tx_frame_ser #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] p_data,
    input  logic              data_valid,
    output logic              ready,
    output logic              tx_out,
    output logic              busy,
    output logic              ser_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_TAIL = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam bit LSB = (LSB_FIRST != 0);

    generate
        if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
            $error("DATA_W must be 1..16");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_clks
            $error("CLKS_PER_BIT must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
            $error("PARITY_ODD must be 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              stop_idx_reg, stop_idx_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              tx_reg, tx_next;
    logic              done_reg, done_next;
`ifdef UART_TX_PARITY_EN
    logic              parity_reg, parity_next;
`endif

    logic              bit_end;
    logic              stop_last;
    logic              next_bit;
    logic [DATA_W-1:0] shifted;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            stop_idx_reg <= 1'b0;
            shift_reg    <= '0;
            tx_reg       <= 1'b1;
            done_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            stop_idx_reg <= stop_idx_next;
            shift_reg    <= shift_next;
            tx_reg       <= tx_next;
            done_reg     <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg + CNT_W'(1);
        idx_next      = idx_reg;
        stop_idx_next = stop_idx_reg;
        shift_next    = shift_reg;
        tx_next       = tx_reg;
        done_next     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_reg;
`endif
        bit_end   = (cnt_reg == CNT_LAST);
        stop_last = (STOP_BITS == 1) || stop_idx_reg;
        next_bit  = LSB ? shift_reg[0] : shift_reg[DATA_W-1];
        shifted   = LSB ? (shift_reg >> 1) : (shift_reg << 1);

        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                tx_next  = 1'b1;
                if (data_valid) begin
                    shift_next = p_data;
`ifdef UART_TX_PARITY_EN
                    parity_next = (^p_data) ^ 1'(PARITY_ODD);
`endif
                    tx_next    = 1'b0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    tx_next    = next_bit;
                    shift_next = shifted;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (idx_reg == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity_reg;
                        state_next = ST_PARITY;
`else
                        tx_next       = 1'b1;
                        stop_idx_next = 1'b0;
                        state_next    = ST_STOP;
`endif
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        tx_next    = next_bit;
                        shift_next = shifted;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_next      = '0;
                    tx_next       = 1'b1;
                    stop_idx_next = 1'b0;
                    state_next    = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // The IDLE cycle is the final clock of the last stop bit, so a word
                // accepted there starts its start bit with no extra idle time.
                if (stop_last && cnt_reg == CNT_TAIL) begin
                    cnt_next   = '0;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end else if (bit_end) begin
                    cnt_next      = '0;
                    stop_idx_next = 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                tx_next    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ready    = (state_reg == ST_IDLE);
    assign busy     = ~ready;
    assign tx_out   = tx_reg;
    assign ser_done = done_reg;

endmodule

// File: tb/tb_uart_tx_frame_ser.sv
// Directed, table-driven bench for uart_tx_frame_ser at CLKS_PER_BIT=4, plus back-to-back and reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_frame_ser;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [7:0] pd_a;  logic dv_a;  logic rdy_a, tx_a, busy_a, done_a;
    logic [4:0] pd_b;  logic dv_b;  logic rdy_b, tx_b, busy_b, done_b;

    uart_tx_frame_ser #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .LSB_FIRST(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .p_data(pd_a), .data_valid(dv_a),
        .ready(rdy_a), .tx_out(tx_a), .busy(busy_a), .ser_done(done_a));

    uart_tx_frame_ser #(.DATA_W(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .LSB_FIRST(0), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rst(rst), .p_data(pd_b), .data_valid(dv_b),
        .ready(rdy_b), .tx_out(tx_b), .busy(busy_b), .ser_done(done_b));

`ifdef UART_TX_PARITY_EN
    logic [7:0] pd_c;  logic dv_c;  logic rdy_c, tx_c, busy_c, done_c;
    uart_tx_frame_ser #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .LSB_FIRST(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .rst(rst), .p_data(pd_c), .data_valid(dv_c),
        .ready(rdy_c), .tx_out(tx_c), .busy(busy_c), .ser_done(done_c));
`endif

    // dseq lists the data bits in transmitted order (index 0 first); par is the expected parity bit
    typedef struct {
        int          dut;
        logic [15:0] data;
        logic [0:15] dseq;
        logic        par;
        bit          noisy;
    } vec_t;

    vec_t tbl[16];
    int   n_tbl;
    int   n_cmp  = 0;
    int   n_fail = 0;

    int   sel;
    logic cur_tx, cur_rdy, cur_busy, cur_done;
    always_comb begin
        cur_tx = tx_a; cur_rdy = rdy_a; cur_busy = busy_a; cur_done = done_a;
        case (sel)
            1: begin cur_tx = tx_b; cur_rdy = rdy_b; cur_busy = busy_b; cur_done = done_b; end
`ifdef UART_TX_PARITY_EN
            2: begin cur_tx = tx_c; cur_rdy = rdy_c; cur_busy = busy_c; cur_done = done_c; end
`endif
            default: ;
        endcase
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nd_of(input int d);
        return (d == 1) ? 5 : 8;
    endfunction

    function automatic int stop_of(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic logic exp_bit(input vec_t v, input int b);
        int nd;
        nd = nd_of(v.dut);
        if (b == 0) return 1'b0;
        if (b <= nd) return v.dseq[b-1];
        if (P == 1 && b == nd + 1) return v.par;
        return 1'b1;
    endfunction

    task automatic drive(input int d, input logic [15:0] data, input logic valid);
        case (d)
            1: begin pd_b = data[4:0]; dv_b = valid; end
`ifdef UART_TX_PARITY_EN
            2: begin pd_c = data[7:0]; dv_c = valid; end
`endif
            default: begin pd_a = data[7:0]; dv_a = valid; end
        endcase
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int n;
        logic [15:0] dd;
        n = (1 + nd_of(v.dut) + P + stop_of(v.dut)) * CPB;
        sel = v.dut;
        @(negedge clk);
        check($sformatf("v%0d idle_ready", vi), cur_rdy, 1'b1);
        drive(v.dut, v.data, 1'b1);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (v.noisy) begin
                dd = (k % 2 == 1) ? ~v.data : v.data;
                drive(v.dut, dd, k < n);
            end else if (k == 1) begin
                drive(v.dut, v.data, 1'b0);
            end
            check($sformatf("v%0d tx clk%0d", vi, k), cur_tx, exp_bit(v, (k - 1) / CPB));
            check($sformatf("v%0d done clk%0d", vi, k), cur_done, k == n);
            check($sformatf("v%0d ready clk%0d", vi, k), cur_rdy, k == n);
            check($sformatf("v%0d busy clk%0d", vi, k), cur_busy, k != n);
        end
        @(negedge clk);
        check($sformatf("v%0d done_after", vi), cur_done, 1'b0);
        check($sformatf("v%0d tx_after", vi), cur_tx, 1'b1);
        check($sformatf("v%0d ready_after", vi), cur_rdy, 1'b1);
        $display("vec %0d: dut %0d data %h frame %0d clk noisy %0d", vi, v.dut, v.data, n, v.noisy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        vec_t vs;

        tbl[0] = '{0, 16'h00A5, 16'b1010010100000000, 1'b0, 1'b0};
        tbl[1] = '{0, 16'h0000, 16'b0000000000000000, 1'b0, 1'b0};
        tbl[2] = '{0, 16'h00FF, 16'b1111111100000000, 1'b0, 1'b0};
        tbl[3] = '{0, 16'h003C, 16'b0011110000000000, 1'b0, 1'b1};
        tbl[4] = '{0, 16'h0007, 16'b1110000000000000, 1'b1, 1'b0};
        tbl[5] = '{0, 16'h0080, 16'b0000000100000000, 1'b1, 1'b0};
        tbl[6] = '{1, 16'h0013, 16'b1001100000000000, 1'b1, 1'b0};
        tbl[7] = '{1, 16'h0001, 16'b0000100000000000, 1'b1, 1'b0};
        tbl[8] = '{1, 16'h001E, 16'b1111000000000000, 1'b0, 1'b1};
        n_tbl = 9;
`ifdef UART_TX_PARITY_EN
        tbl[9]  = '{2, 16'h0007, 16'b1110000000000000, 1'b0, 1'b0};
        tbl[10] = '{2, 16'h003C, 16'b0011110000000000, 1'b1, 1'b0};
        n_tbl = 11;
        pd_c = '0; dv_c = 1'b0;
`endif
        sel = 0;
        rst = 1'b0;
        pd_a = '0; dv_a = 1'b0;
        pd_b = '0; dv_b = 1'b0;

        #12;
        check("rst tx_a", tx_a, 1'b1);
        check("rst ready_a", rdy_a, 1'b1);
        check("rst busy_a", busy_a, 1'b0);
        check("rst done_a", done_a, 1'b0);
        check("rst tx_b", tx_b, 1'b1);
        check("rst ready_b", rdy_b, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle tx_a", tx_a, 1'b1);
            check("idle busy_a", busy_a, 1'b0);
        end

        for (int i = 0; i < n_tbl; i++) run_vec(i, tbl[i]);

        // back-to-back: valid held high, 00 then FF, no gap between frames
        sel = 0;
        n = (10 + P) * CPB;
        @(negedge clk);
        drive(0, 16'h0000, 1'b1);
        for (int k = 1; k <= 2 * n; k++) begin
            int kk;
            @(negedge clk);
            if (k == 1) pd_a = 8'hFF;
            if (k == 2 * n) dv_a = 1'b0;
            vs = (k <= n) ? tbl[1] : tbl[2];
            kk = (k <= n) ? k : k - n;
            check($sformatf("b2b tx clk%0d", k), tx_a, exp_bit(vs, (kk - 1) / CPB));
            check($sformatf("b2b done clk%0d", k), done_a, kk == n);
            check($sformatf("b2b ready clk%0d", k), rdy_a, kk == n);
        end
        @(negedge clk);
        check("b2b tx_after", tx_a, 1'b1);
        check("b2b ready_after", rdy_a, 1'b1);
        $display("b2b: frames 00 then FF, %0d clk each", n);

        // reset in the middle of the data bits of an all-zero word
        @(negedge clk);
        drive(0, 16'h0000, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) dv_a = 1'b0;
        end
        check("pre_rst tx", tx_a, 1'b0);
        check("pre_rst busy", busy_a, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst tx", tx_a, 1'b1);
        check("mid_rst ready", rdy_a, 1'b1);
        check("mid_rst busy", busy_a, 1'b0);
        check("mid_rst done", done_a, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check($sformatf("post_rst tx clk%0d", k), tx_a, 1'b1);
            check($sformatf("post_rst done clk%0d", k), done_a, 1'b0);
        end
        $display("reset: frame dropped, line idle");
        run_vec(99, tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
